// File: rtl/sample_reader_pkg.sv
// Shared types and constants for the oscilloscope capture path.
// Holds the sample_reader FSM state type and the top-level watcher state codes.
package oscilo_pkg;

  typedef enum logic [3:0] {
    IDLE,
    SEND_HDR,
    WAIT_HDR,
    FETCH,
    SEND,
    WAIT,
    SEND_SUM,
    WAIT_SUM,
    FINISH,
    DRAIN
  } reader_state_t;

  localparam logic [7:0] ST_INIT        = 8'h00;
  localparam logic [7:0] ST_TEST        = 8'h11;
  localparam logic [7:0] ST_SAMPLER     = 8'h21;
  localparam logic [7:0] ST_SAMPLE_READ = 8'h22;

  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

endpackage

// File: rtl/sample_reader_if.sv
// Bundle between sample_reader, the sample memory read port, uart_tx and the state watcher.
// master = the reader; slave = everything around it.
interface sample_reader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  activate;
  logic                  done;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_oe;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [7:0]            tx_data;
  logic                  tx_start;
  logic                  tx_active;
  logic                  tx_done;

  modport master (
    input  activate, mem_data, tx_active, tx_done,
    output done, mem_addr, mem_oe, tx_data, tx_start
  );

  modport slave (
    output activate, mem_data, tx_active, tx_done,
    input  done, mem_addr, mem_oe, tx_data, tx_start
  );
endinterface

// File: rtl/sample_reader.sv
// Streams the captured sample buffer over uart_tx as: header, NUM_SAMPLES bytes, optional checksum.
// state    | meaning
// IDLE     | waiting for activate
// SEND_HDR | pulse tx_start for the header once uart is free
// WAIT_HDR | header in flight
// FETCH    | read mem[addr], latch into tx_data and checksum
// SEND     | pulse tx_start for a data byte once uart is free
// WAIT     | data byte in flight; advance addr/count on tx_done
// SEND_SUM | pulse tx_start for the checksum once uart is free
// WAIT_SUM | checksum in flight
// FINISH   | frame complete, done held until activate drops
// DRAIN    | aborted; let any started byte finish, then IDLE
module sample_reader
  import oscilo_pkg::*;
#(
  parameter int         DATA_WIDTH    = 8,
  parameter int         ADDR_WIDTH    = 8,
  parameter int         NUM_SAMPLES   = 256,
  parameter logic [7:0] HEADER_BYTE   = DEFAULT_HEADER,
  parameter bit         SEND_CHECKSUM = 1'b1
) (
  input logic             clk_50mhz,
  input logic             reset,
  sample_reader_if.master bus
);

  localparam logic [ADDR_WIDTH:0] NUM_S = (ADDR_WIDTH + 1)'(NUM_SAMPLES);

  reader_state_t         r_state;
  reader_state_t         w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [ADDR_WIDTH:0]   w_count_inc;
  logic [7:0]            r_tx_data;
  logic [7:0]            r_checksum;
  logic                  r_pending;
  logic                  w_tx_start;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_mem_data;

  assign w_mem_data  = bus.mem_data;
  assign w_count_inc = r_count + 1'b1;
  assign w_last      = !(w_count_inc < NUM_S);

  always_comb begin
    w_next     = r_state;
    w_tx_start = 1'b0;
    case (r_state)
      IDLE:     if (bus.activate) w_next = SEND_HDR;
      SEND_HDR: begin
        if (!bus.activate) w_next = DRAIN;
        else if (!bus.tx_active) begin
          w_tx_start = 1'b1;
          w_next     = WAIT_HDR;
        end
      end
      WAIT_HDR: begin
        if (!bus.activate) w_next = DRAIN;
        else if (bus.tx_done) w_next = FETCH;
      end
      FETCH:    w_next = bus.activate ? SEND : DRAIN;
      SEND: begin
        if (!bus.activate) w_next = DRAIN;
        else if (!bus.tx_active) begin
          w_tx_start = 1'b1;
          w_next     = WAIT;
        end
      end
      WAIT: begin
        if (!bus.activate) w_next = DRAIN;
        else if (bus.tx_done) begin
          if (!w_last)            w_next = FETCH;
          else if (SEND_CHECKSUM) w_next = SEND_SUM;
          else                    w_next = FINISH;
        end
      end
      SEND_SUM: begin
        if (!bus.activate) w_next = DRAIN;
        else if (!bus.tx_active) begin
          w_tx_start = 1'b1;
          w_next     = WAIT_SUM;
        end
      end
      WAIT_SUM: begin
        if (!bus.activate) w_next = DRAIN;
        else if (bus.tx_done) w_next = FINISH;
      end
      FINISH:   if (!bus.activate) w_next = IDLE;
      // a byte started just before the abort may not have raised tx_active yet
      DRAIN:    if (!bus.tx_active && !r_pending) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_count    <= '0;
      r_tx_data  <= '0;
      r_checksum <= '0;
      r_pending  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_tx_start)       r_pending <= 1'b1;
      else if (bus.tx_done) r_pending <= 1'b0;
      case (r_state)
        IDLE: if (bus.activate) begin
          r_addr     <= '0;
          r_count    <= '0;
          r_checksum <= '0;
          r_tx_data  <= HEADER_BYTE;
        end
        FETCH: if (bus.activate) begin
          r_tx_data  <= w_mem_data;
          r_checksum <= r_checksum + w_mem_data;
        end
        WAIT: if (bus.activate && bus.tx_done) begin
          r_count <= w_count_inc;
          r_addr  <= r_addr + 1'b1;
          if (w_last && SEND_CHECKSUM) r_tx_data <= r_checksum;
        end
        default: ;
      endcase
    end
  end

  assign bus.done     = (r_state == FINISH);
  assign bus.mem_oe   = (r_state == FETCH);
  assign bus.mem_addr = r_addr;
  assign bus.tx_data  = r_tx_data;
  assign bus.tx_start = w_tx_start;

endmodule

// File: tb/tb_sample_reader.sv
// Directed bench for sample_reader: three configurations share one memory and one uart model.
// Only one instance is activated at a time, so the shared uart sees a single stream.
module tb_sample_reader;
  import oscilo_pkg::*;

  logic clk_50mhz = 1'b0;
  logic reset;
  always #5 clk_50mhz = ~clk_50mhz;

  sample_reader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) if0 ();
  sample_reader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) if1 ();
  sample_reader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) if2 ();

  sample_reader #(.NUM_SAMPLES(4), .SEND_CHECKSUM(1'b1))
    dut0 (.clk_50mhz(clk_50mhz), .reset(reset), .bus(if0));
  sample_reader #(.NUM_SAMPLES(1), .SEND_CHECKSUM(1'b0))
    dut1 (.clk_50mhz(clk_50mhz), .reset(reset), .bus(if1));
  sample_reader #(.NUM_SAMPLES(256), .SEND_CHECKSUM(1'b1))
    dut2 (.clk_50mhz(clk_50mhz), .reset(reset), .bus(if2));

  logic [7:0] mem [256];
  logic       u_active = 1'b0;
  logic       u_done   = 1'b0;
  logic       hold_busy;
  int         u_cnt = 0;

  assign if0.mem_data  = mem[if0.mem_addr];
  assign if1.mem_data  = mem[if1.mem_addr];
  assign if2.mem_data  = mem[if2.mem_addr];
  assign if0.tx_active = u_active | hold_busy;
  assign if1.tx_active = u_active | hold_busy;
  assign if2.tx_active = u_active | hold_busy;
  assign if0.tx_done   = u_done;
  assign if1.tx_done   = u_done;
  assign if2.tx_done   = u_done;

  wire       w_start_any = if0.tx_start | if1.tx_start | if2.tx_start;
  wire [7:0] w_data_any  = if0.tx_start ? if0.tx_data :
                           if1.tx_start ? if1.tx_data : if2.tx_data;

  logic [7:0] log_q [$];
  int gap_q [$];
  int n_starts = 0, busy_err = 0, fetch2 = 0, rd255 = 0, done0_cnt = 0;
  int cyc = 0, last_done_cyc = 0;

  // uart_tx model: 10-cycle busy per byte, tx_done pulse at the end
  always @(posedge clk_50mhz) begin
    cyc <= cyc + 1;
    u_done <= 1'b0;
    if (u_done) last_done_cyc <= cyc;
    if (w_start_any) begin
      if (u_cnt != 0) busy_err++;
      log_q.push_back(w_data_any);
      gap_q.push_back(cyc - last_done_cyc);
      n_starts++;
      u_cnt    <= 10;
      u_active <= 1'b1;
    end else if (u_cnt != 0) begin
      u_cnt <= u_cnt - 1;
      if (u_cnt == 1) begin
        u_active <= 1'b0;
        u_done   <= 1'b1;
      end
    end
    if (if2.mem_oe) begin
      fetch2++;
      if (if2.mem_addr == 8'hFF) rd255++;
    end
    if (if0.done) done0_cnt++;
  end

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int inst, input int max_cyc, input string tag);
    logic d;
    bit ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk_50mhz);
      case (inst)
        0:       d = if0.done;
        1:       d = if1.done;
        default: d = if2.done;
      endcase
      if (d) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_starts(input int target, input int max_cyc, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk_50mhz);
      if (n_starts >= target) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    int base, f2, r2, dcnt, pulses;
    logic [7:0] exp1 [6];
    exp1 = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h03, 8'h06};
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    reset = 1'b1;
    hold_busy = 1'b0;
    if0.activate = 1'b0;
    if1.activate = 1'b0;
    if2.activate = 1'b0;
    repeat (3) @(negedge clk_50mhz);
    check("rst_done",     32'(if0.done),     32'd0);
    check("rst_tx_start", 32'(if0.tx_start), 32'd0);
    check("rst_mem_oe",   32'(if0.mem_oe),   32'd0);
    check("rst_mem_addr", 32'(if0.mem_addr), 32'd0);
    check("rst_tx_data",  32'(if0.tx_data),  32'd0);
    reset = 1'b0;
    @(negedge clk_50mhz);

    // 1: four samples with checksum
    base = n_starts;
    if0.activate = 1'b1;
    @(negedge clk_50mhz);
    check("t1_first_start", 32'(if0.tx_start), 32'd1);
    check("t1_first_data",  32'(if0.tx_data),  32'hA5);
    wait_done(0, 300, "t1_done_timeout");
    check("t1_nbytes", 32'(n_starts - base), 32'd6);
    for (int i = 0; i < 6; i++)
      check($sformatf("t1_byte%0d", i), 32'(log_q[base + i]), 32'(exp1[i]));
    check("t1_gap_done_to_start", 32'(gap_q[base + 2]), 32'd2);
    repeat (5) @(negedge clk_50mhz);
    check("t1_done_held", 32'(if0.done), 32'd1);
    if0.activate = 1'b0;
    @(negedge clk_50mhz);
    check("t1_done_drop", 32'(if0.done), 32'd0);
    repeat (3) @(negedge clk_50mhz);

    // 2: one sample, no checksum
    base = n_starts;
    if1.activate = 1'b1;
    wait_done(1, 200, "t2_done_timeout");
    repeat (30) @(negedge clk_50mhz);
    check("t2_nbytes", 32'(n_starts - base), 32'd2);
    check("t2_byte0",  32'(log_q[base]),     32'hA5);
    check("t2_byte1",  32'(log_q[base + 1]), 32'h00);
    check("t2_done",   32'(if1.done),        32'd1);
    if1.activate = 1'b0;
    repeat (3) @(negedge clk_50mhz);

    // 3: full 256-sample buffer of 0xFF, checksum wraps to 0
    for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
    base = n_starts;
    f2 = fetch2;
    r2 = rd255;
    if2.activate = 1'b1;
    wait_done(2, 5000, "t3_done_timeout");
    repeat (40) @(negedge clk_50mhz);
    check("t3_nbytes",   32'(n_starts - base),   32'd258);
    check("t3_header",   32'(log_q[base]),       32'hA5);
    check("t3_first",    32'(log_q[base + 1]),   32'hFF);
    check("t3_last",     32'(log_q[base + 256]), 32'hFF);
    check("t3_checksum", 32'(log_q[base + 257]), 32'h00);
    check("t3_fetches",  32'(fetch2 - f2),       32'd256);
    check("t3_rd255",    32'(rd255 - r2),        32'd1);
    if2.activate = 1'b0;
    repeat (3) @(negedge clk_50mhz);
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);

    // 4: abort while the third data byte is in flight
    base = n_starts;
    dcnt = done0_cnt;
    if0.activate = 1'b1;
    wait_starts(base + 4, 200, "t4_start_timeout");
    check("t4_byte3", 32'(log_q[base + 3]), 32'h02);
    if0.activate = 1'b0;
    @(negedge clk_50mhz);
    check("t4_drain", 32'(dut0.r_state), 32'(DRAIN));
    repeat (20) @(negedge clk_50mhz);
    check("t4_idle",     32'(dut0.r_state),     32'(IDLE));
    check("t4_nstarts",  32'(n_starts - base),  32'd4);
    check("t4_no_done",  32'(done0_cnt - dcnt), 32'd0);

    // 5: reset mid-frame, then restart
    base = n_starts;
    if0.activate = 1'b1;
    wait_starts(base + 3, 200, "t5_start_timeout");
    reset = 1'b1;
    @(negedge clk_50mhz);
    check("t5_done",     32'(if0.done),     32'd0);
    check("t5_tx_start", 32'(if0.tx_start), 32'd0);
    check("t5_mem_oe",   32'(if0.mem_oe),   32'd0);
    check("t5_mem_addr", 32'(if0.mem_addr), 32'd0);
    reset = 1'b0;
    base = n_starts;
    wait_done(0, 300, "t5_done_timeout");
    check("t5_nbytes", 32'(n_starts - base),  32'd6);
    check("t5_header", 32'(log_q[base]),      32'hA5);
    check("t5_sum",    32'(log_q[base + 5]),  32'h06);
    if0.activate = 1'b0;
    repeat (3) @(negedge clk_50mhz);

    // 6: uart busy for 50 cycles on entry to SEND_HDR
    base = n_starts;
    hold_busy = 1'b1;
    if0.activate = 1'b1;
    repeat (50) @(negedge clk_50mhz);
    check("t6_no_early_start", 32'(n_starts - base), 32'd0);
    check("t6_tx_data_held",   32'(if0.tx_data),     32'hA5);
    hold_busy = 1'b0;
    pulses = 0;
    #1;
    if (if0.tx_start) pulses++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_50mhz);
      if (if0.tx_start) pulses++;
    end
    check("t6_pulse_width", 32'(pulses),           32'd1);
    check("t6_one_start",   32'(n_starts - base),  32'd1);
    check("t6_header",      32'(log_q[base]),      32'hA5);
    wait_done(0, 300, "t6_done_timeout");
    if0.activate = 1'b0;
    repeat (3) @(negedge clk_50mhz);

    check("start_while_busy", 32'(busy_err), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
